// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer for the board SRAM port: writes ADC samples at rising
// addresses, then replays them on DAC request. Define LOOP_PLAY_EN for looped playback.
module rec_play_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              record,
  input  logic              play,
  input  logic              stop,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_in_vld,
  input  logic              sample_req,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_vld,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_read,
  output logic              sram_write,
  output logic              sram_record,
  output logic              sram_play,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              full,
  output logic              overrun,
  output logic [ADDR_W:0]   rec_len,
  output logic [2:0]        dbg_state
);

  // Handshake: sample_in_vld / sample_req are single-cycle strobes with no ready;
  // a strobe seen while the matching SRAM access is in flight is dropped and flagged
  // on overrun. sample_out_vld is a single-cycle strobe qualifying sample_out.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REC     = 3'd1;
  localparam logic [2:0] S_REC_WR  = 3'd2;
  localparam logic [2:0] S_PLAY    = 3'd3;
  localparam logic [2:0] S_PLAY_RD = 3'd4;

  localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stop_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_sample_out;
  logic              r_sample_vld;
  logic              r_full;
  logic              r_overrun;
  logic [ADDR_W:0]   r_rec_len;

  logic              w_last_cyc;
  logic              w_stop_any;
  logic              w_play_abort;
  logic [ADDR_W:0]   w_ptr_inc;

  assign w_last_cyc = (r_cnt == CNT_LAST);
  assign w_stop_any = stop | r_stop_pend;
  assign w_ptr_inc  = r_ptr + LEN_ONE;

`ifdef LOOP_PLAY_EN
  assign w_play_abort = record;
`else
  assign w_play_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_stop_pend  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sample_out <= '0;
      r_sample_vld <= 1'b0;
      r_full       <= 1'b0;
      r_overrun    <= 1'b0;
      r_rec_len    <= '0;
    end else begin
      r_sample_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (stop) begin
            r_state <= S_IDLE;
          end else if (record) begin
            r_state   <= S_REC;
            r_ptr     <= '0;
            r_rec_len <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
          end else if (play && (r_rec_len != '0)) begin
            r_state   <= S_PLAY;
            r_ptr     <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_REC: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (sample_in_vld) begin
            r_wdata <= sample_in;
            r_addr  <= r_ptr[ADDR_W-1:0];
            r_cnt   <= '0;
            r_state <= S_REC_WR;
          end
        end
        S_REC_WR: begin
          if (stop)          r_stop_pend <= 1'b1;
          if (sample_in_vld) r_overrun   <= 1'b1;
          if (w_last_cyc) begin
            r_ptr     <= w_ptr_inc;
            r_rec_len <= r_rec_len + LEN_ONE;
            // Top word written: recording ends without wrapping.
            if (&r_addr) begin
              r_full  <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_stop_any) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_REC;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PLAY: begin
          if (stop || w_play_abort) begin
            r_state <= S_IDLE;
          end else if (sample_req) begin
            r_addr  <= r_ptr[ADDR_W-1:0];
            r_cnt   <= '0;
            r_state <= S_PLAY_RD;
          end
        end
        S_PLAY_RD: begin
          if (stop)       r_stop_pend <= 1'b1;
          if (sample_req) r_overrun   <= 1'b1;
          if (w_last_cyc) begin
            r_sample_out <= sram_rdata;
            r_sample_vld <= 1'b1;
            if (w_ptr_inc == r_rec_len) begin
`ifdef LOOP_PLAY_EN
              r_ptr   <= '0;
              r_state <= (w_stop_any || w_play_abort) ? S_IDLE : S_PLAY;
`else
              r_ptr   <= w_ptr_inc;
              r_state <= S_IDLE;
`endif
            end else begin
              r_ptr   <= w_ptr_inc;
              r_state <= (w_stop_any || w_play_abort) ? S_IDLE : S_PLAY;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign sram_write     = (r_state == S_REC_WR);
  assign sram_read      = (r_state == S_PLAY_RD);
  assign sram_record    = (r_state == S_REC) || (r_state == S_REC_WR);
  assign sram_play      = (r_state == S_PLAY) || (r_state == S_PLAY_RD);
  assign busy           = (r_state != S_IDLE);
  assign sram_addr      = r_addr;
  assign sram_wdata     = r_wdata;
  assign sample_out     = r_sample_out;
  assign sample_out_vld = r_sample_vld;
  assign full           = r_full;
  assign overrun        = r_overrun;
  assign rec_len        = r_rec_len;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: randomized record/play sessions against a cycle-count
// reference model, with queued expectations checked by an independent monitor.
module tb_rec_play_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int AC    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, record, play, stop, sample_in_vld, sample_req;
  logic [DW-1:0] sample_in, sample_out, sram_wdata, sram_rdata;
  logic          sample_out_vld, sram_read, sram_write, sram_record, sram_play;
  logic          busy, full, overrun;
  logic [AW-1:0] sram_addr;
  logic [AW:0]   rec_len;
  logic [2:0]    dbg_state;
  logic [DW-1:0] sram_mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected write {start_cycle, addr, data}, read strobe {start_cycle, addr},
  // read result {vld_cycle, data}.
  logic [55:0] exp_wr_q[$];
  logic [39:0] exp_ra_q[$];
  logic [47:0] exp_rd_q[$];

  // Reference model state, in cycles counted at the sampling edge.
  int            m_mode;        // 0 idle, 1 recording, 2 playing
  int            m_busy_until;  // last cycle at which an access is still in flight
  int            m_kind;        // 1 write access, 2 read access
  int            m_ptr, m_len;
  bit            m_full, m_ovr;
  logic [DW-1:0] m_rec [DEPTH];

  rec_play_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYC(AC)) dut (
    .clk(clk), .rst(rst), .record(record), .play(play), .stop(stop),
    .sample_in(sample_in), .sample_in_vld(sample_in_vld), .sample_req(sample_req),
    .sample_out(sample_out), .sample_out_vld(sample_out_vld),
    .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
    .sram_record(sram_record), .sram_play(sram_play), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy), .full(full), .overrun(overrun),
    .rec_len(rec_len), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (sram_write) sram_mem[sram_addr] <= sram_wdata;
  assign sram_rdata = sram_mem[sram_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_mode = 0; m_busy_until = -10; m_kind = 0;
    m_ptr = 0; m_len = 0; m_full = 0; m_ovr = 0;
  endtask

  // Driver tasks: each starts just after a falling edge and ends on the next one.
  task automatic pulse_record(input bit with_play);
    int q = cyc;
    record = 1'b1; play = with_play;
    if (m_mode == 0 && q > m_busy_until) begin
      m_mode = 1; m_ptr = 0; m_len = 0; m_full = 0; m_ovr = 0;
    end
    tick();
    record = 1'b0; play = 1'b0;
  endtask

  task automatic pulse_play();
    int q = cyc;
    play = 1'b1;
    if (m_mode == 0 && q > m_busy_until && m_len != 0) begin
      m_mode = 2; m_ptr = 0; m_ovr = 0;
    end
    tick();
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    m_mode = 0;
    tick();
    stop = 1'b0;
    repeat (AC + 2) tick();
  endtask

  task automatic drive_sample(input logic [DW-1:0] d);
    int q = cyc;
    sample_in = d; sample_in_vld = 1'b1;
    if (m_kind == 1 && q <= m_busy_until) begin
      m_ovr = 1;
    end else if (m_mode == 1 && q > m_busy_until) begin
      exp_wr_q.push_back({32'(q + 1), 8'(m_ptr), d});
      m_rec[m_ptr] = d;
      m_ptr++; m_len++;
      m_kind = 1; m_busy_until = q + AC;
      if (m_ptr == DEPTH) begin m_full = 1; m_mode = 0; end
    end
    tick();
    sample_in_vld = 1'b0;
  endtask

  task automatic drive_req();
    int q = cyc;
    sample_req = 1'b1;
    if (m_kind == 2 && q <= m_busy_until) begin
      m_ovr = 1;
    end else if (m_mode == 2 && q > m_busy_until) begin
      exp_ra_q.push_back({32'(q + 1), 8'(m_ptr)});
      exp_rd_q.push_back({32'(q + AC + 1), m_rec[m_ptr]});
      m_ptr++;
      m_kind = 2; m_busy_until = q + AC;
      if (m_ptr == m_len) begin
`ifdef LOOP_PLAY_EN
        m_ptr = 0;
`else
        m_mode = 0;
`endif
      end
    end
    tick();
    sample_req = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, busy, m_mode != 0);
    chk({tag, "_rec_len"}, rec_len, m_len);
    chk({tag, "_full"}, full, m_full);
    chk({tag, "_overrun"}, overrun, m_ovr);
    chk({tag, "_sram_record"}, sram_record, m_mode == 1);
    chk({tag, "_sram_play"}, sram_play, m_mode == 2);
    chk({tag, "_idle_strobes"}, {sram_read, sram_write}, 2'b00);
  endtask

  // Scoreboard monitor
  int            wr_run = 0, rd_run = 0;
  logic [AW-1:0] wr_addr_h;
  logic [DW-1:0] wr_data_h;
  logic [55:0]   e_wr;
  logic [39:0]   e_ra;
  logic [47:0]   e_rd;

  always @(negedge clk) begin
    if (rst) begin
      wr_run = 0; rd_run = 0;
    end else begin
      chk("rd_wr_overlap", {sram_read & sram_write}, 1'b0);
      if (sram_write) begin
        if (wr_run == 0) begin
          chk("wr_expected", exp_wr_q.size() != 0, 1'b1);
          if (exp_wr_q.size() != 0) begin
            e_wr = exp_wr_q.pop_front();
            chk("wr_start_cyc", cyc, e_wr[55:24]);
            chk("wr_addr", sram_addr, e_wr[23:16]);
            chk("wr_data", sram_wdata, e_wr[15:0]);
            chk("wr_record_flag", sram_record, 1'b1);
          end
          wr_addr_h = sram_addr; wr_data_h = sram_wdata;
        end else begin
          chk("wr_addr_hold", sram_addr, wr_addr_h);
          chk("wr_data_hold", sram_wdata, wr_data_h);
        end
        wr_run++;
      end else if (wr_run != 0) begin
        chk("wr_len", wr_run, AC);
        wr_run = 0;
      end
      if (sram_read) begin
        if (rd_run == 0) begin
          chk("rd_expected", exp_ra_q.size() != 0, 1'b1);
          if (exp_ra_q.size() != 0) begin
            e_ra = exp_ra_q.pop_front();
            chk("rd_start_cyc", cyc, e_ra[39:8]);
            chk("rd_addr", sram_addr, e_ra[7:0]);
            chk("rd_play_flag", sram_play, 1'b1);
          end
        end
        rd_run++;
      end else if (rd_run != 0) begin
        chk("rd_len", rd_run, AC);
        rd_run = 0;
      end
      if (sample_out_vld) begin
        chk("out_expected", exp_rd_q.size() != 0, 1'b1);
        if (exp_rd_q.size() != 0) begin
          e_rd = exp_rd_q.pop_front();
          chk("out_cyc", cyc, e_rd[47:16]);
          chk("out_data", sample_out, e_rd[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; record = 1'b0; play = 1'b0; stop = 1'b0;
    sample_in = '0; sample_in_vld = 1'b0; sample_req = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_outputs",
        {sample_out, sample_out_vld, sram_addr, sram_read, sram_write, sram_record,
         sram_play, sram_wdata, busy, full, overrun, rec_len, dbg_state}, '0);
    rst = 1'b0;
    tick();
    check_status("post_reset");

    // Record four samples with comfortable spacing, then play five requests back.
    pulse_record(1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive_sample(16'(i * 16'h1111));
      repeat ($urandom_range(AC + 2, AC + 5)) tick();
    end
    pulse_stop();
    check_status("rec4");
    pulse_play();
    for (int i = 0; i < 5; i++) begin
      drive_req();
      repeat ($urandom_range(AC + 2, AC + 5)) tick();
    end
    pulse_stop();
    check_status("play5");

    // Record and play together: record wins.
    pulse_record(1'b1);
    chk("prio_record", sram_record, 1'b1);
    chk("prio_play", sram_play, 1'b0);
    pulse_stop();
    check_status("prio");

    // Fill the whole memory; the ninth strobe must be ignored.
    pulse_record(1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_sample(16'($urandom_range(0, 16'hFFFF)));
      repeat (AC + 2) tick();
    end
    check_status("full");
    pulse_play();
    for (int i = 0; i < DEPTH; i++) begin
      drive_req();
      repeat ($urandom_range(AC + 1, AC + 3)) tick();
    end
    pulse_stop();
    check_status("play_full");

    // Overrun one cycle into a write, then stop during a write.
    pulse_record(1'b0);
    drive_sample(16'hA5A5);
    drive_sample(16'h5A5A);
    repeat (AC + 2) tick();
    drive_sample(16'hC3C3);
    pulse_stop();
    check_status("ovr_stop");

    // Asynchronous reset in the middle of a write.
    pulse_record(1'b0);
    drive_sample(16'h7777);
    tick();
    chk("wr_before_rst", sram_write, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write",
        {sample_out, sample_out_vld, sram_addr, sram_read, sram_write, sram_record,
         sram_play, sram_wdata, busy, full, overrun, rec_len}, '0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    pulse_play();
    repeat (2) tick();
    check_status("play_empty");

    // Randomized sessions, including back-to-back strobes and random stop timing.
    for (int s = 0; s < 8; s++) begin
      pulse_record(1'b0);
      for (int i = 0; i < int'($urandom_range(1, DEPTH + 2)); i++) begin
        drive_sample(16'($urandom_range(0, 16'hFFFF)));
        repeat ($urandom_range(0, AC + 3)) tick();
      end
      repeat ($urandom_range(0, AC)) tick();
      pulse_stop();
      check_status("rnd_rec");
      pulse_play();
      for (int i = 0; i < int'($urandom_range(1, DEPTH + 3)); i++) begin
        drive_req();
        repeat ($urandom_range(0, AC + 3)) tick();
      end
      repeat ($urandom_range(0, AC)) tick();
      pulse_stop();
      check_status("rnd_play");
    end

    repeat (5) tick();
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("ra_queue_drained", exp_ra_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Sequencing master for the board SRAM port: drives address, read/write strobes, direction flags and write data into the SRAM wrapper.
- Record mode: stores one 16-bit audio sample per ADC strobe at incrementing addresses.
- Play mode: fetches stored samples in order on DAC request, up to the recorded length.
- Sits between the codec sample interface and the SRAM wrapper; the top level ties sram_wdata/sram_rdata to the shared data bus, using sram_record as the drive direction.

Parameters:
ADDR_W, 18, SRAM word-address width; capacity 2**ADDR_W words
DATA_W, 16, sample and SRAM data width
ACCESS_CYC, 2, clock cycles each read/write strobe is held (min 1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
record  in  1  level; request recording from address 0
play  in  1  level; request playback from address 0
stop  in  1  pulse; end current mode after any in-flight access
sample_in  in  DATA_W  ADC sample
sample_in_vld  in  1  one-cycle strobe, sample_in valid
sample_req  in  1  one-cycle strobe, DAC wants next sample
sample_out  out  DATA_W  sample read from SRAM
sample_out_vld  out  1  one-cycle strobe, sample_out valid
sram_addr  out  ADDR_W  word address to SRAM wrapper
sram_read  out  1  read strobe
sram_write  out  1  write strobe
sram_record  out  1  high in record states; controller drives data bus
sram_play  out  1  high in play states
sram_wdata  out  DATA_W  write data
sram_rdata  in  DATA_W  read data from SRAM wrapper
busy  out  1  not IDLE
full  out  1  sticky; last address written, recording ended
overrun  out  1  sticky; strobe arrived while an access was in flight
rec_len  out  ADDR_W+1  words recorded in the last session

Behaviour:
- Reset values: every output 0; internal pointer 0; state IDLE. Reset mid-access drops sram_read/sram_write immediately (async).
- Clock and reset: clk is the single clock; rst is asynchronous and active-high.
- States: IDLE, REC, REC_WR, PLAY, PLAY_RD.
- IDLE:
  - Priority is stop > record > play; record and play together selects record.
  - Entering REC: pointer=0, rec_len=0, full=0, overrun=0.
  - Entering PLAY: pointer=0, overrun=0. If rec_len==0, play is ignored and the block stays IDLE.
  - Level requests re-trigger only after returning to IDLE.
- REC:
  - sram_record=1.
  - On sample_in_vld: latch sample_in into sram_wdata and sram_addr=pointer, then go to REC_WR.
- REC_WR:
  - sram_write=1 for exactly ACCESS_CYC cycles; address and data held stable throughout.
  - On exit: pointer++ and rec_len++.
  - If the written address was 2**ADDR_W-1: full=1 and go to IDLE (no wrap). Otherwise return to REC.
- PLAY:
  - sram_play=1.
  - On sample_req: sram_addr=pointer, then go to PLAY_RD.
- PLAY_RD:
  - sram_read=1 for ACCESS_CYC cycles.
  - sram_rdata is captured on the last strobe cycle; sample_out updates and sample_out_vld pulses on the following cycle.
  - pointer++. If pointer reaches rec_len: go to IDLE. Otherwise return to PLAY.
- sram_read and sram_write are never high together, and each goes low for at least 1 cycle between accesses.
- stop:
  - In REC/PLAY: go to IDLE next cycle.
  - In REC_WR/PLAY_RD: remembered; the access completes, then go to IDLE. Accesses are never truncated.
  - Stop after a completed write keeps that write counted in rec_len.
- overrun: sample_in_vld during REC_WR, or sample_req during PLAY_RD, sets overrun=1 and the strobe is dropped.
- rec_len holds its value across play sessions; it changes only on record start or a completed write.

Optional Feature:
LOOP_PLAY_EN defined:
- On reaching rec_len in PLAY_RD, pointer wraps to 0 and the state returns to PLAY.
- Playback continues until stop, or until a record request, which takes effect via IDLE after the current access.

LOOP_PLAY_EN undefined:
- Playback ends in IDLE at rec_len, as specified in Behaviour.

Test Plan:
- Record 4 samples: record=1 with samples 0x1111..0x4444, each strobe >ACCESS_CYC+2 cycles apart, then stop → writes to addr 0..3 with matching wdata, each strobe 2 cycles, rec_len=4, busy=0.
- Play after that: play=1 and 5 sample_req → sample_out 0x1111..0x4444 with 4 vld pulses, read addr 0..3, fifth req ignored, returns IDLE (with LOOP_PLAY_EN: fifth returns 0x1111).
- Full: ADDR_W=3 sim, 9 strobes → 8 writes, full=1, IDLE at 8th write completion, 9th ignored, rec_len=8.
- Overrun and stop: sample_in_vld one cycle after a write starts → overrun=1, sample dropped; stop during REC_WR → write completes, rec_len counts it, then IDLE.
- Reset mid-write: assert rst while sram_write=1 → sram_write=0 the same cycle, all outputs 0; play afterwards is ignored (rec_len=0).
- Priority: record and play asserted together in IDLE → REC entered, sram_record=1, sram_play=0.
